// File: rtl/coproc_pkg.sv
// -----------------------------------------------------------------------------
// coproc_pkg
// Shared definitions for the core-side eXtension-interface offload path.
//   xif_state_e      : offload controller FSM states
//   coproc_opcode_e  : major opcodes handled by the coprocessor
//   EXCCODE_TIMEOUT  : exception code reported when a result never arrives
//                      (only produced when XIF_RESULT_TIMEOUT_EN is defined)
// -----------------------------------------------------------------------------
package coproc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_WAIT_RES = 2'd3
    } xif_state_e;

    typedef enum logic [6:0] {
        OPC_RMLD = 7'h08,
        OPC_RMST = 7'h09,
        OPC_TEST = 7'h0A
    } coproc_opcode_e;

    localparam logic [5:0] EXCCODE_TIMEOUT = 6'h3F;

endpackage

// File: rtl/xif_id_gen.sv
// -----------------------------------------------------------------------------
// xif_id_gen
// Wrapping transaction-ID generator for the offload path. The ID advances by
// one on every issue handshake and wraps modulo 2^WIDTH.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, clears the ID to 0
//   inc_i  : advance the ID this cycle
//   id_o   : current ID
// -----------------------------------------------------------------------------
module xif_id_gen #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] id_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_o <= '0;
        end else if (inc_i) begin
            id_o <= id_o + WIDTH'(1);
        end
    end

endmodule

// File: rtl/xif_offload_ctrl.sv
// -----------------------------------------------------------------------------
// xif_offload_ctrl
// Core-side initiator of the eXtension interface. Takes one instruction the
// core cannot execute, drives it over the issue, commit and result channels,
// and hands the writeback (or illegal/exception indication) back to the core.
// Only one offload is in flight; the core stalls on core_ready_o meanwhile.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. Once a valid is raised its payload is held stable and the
// valid is never withdrawn until that transfer happens.
//
// Optional feature: define XIF_RESULT_TIMEOUT_EN to abandon an offload whose
// result has not arrived after TIMEOUT_CYCLES cycles in WAIT_RES.
//
// Ports:
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   core_*                     : request from the core (valid/ready), flush
//   core_illegal_o             : pulse, coprocessor rejected the instruction
//   wb_*                       : writeback pulse with rd/data/exception
//   issue_*                    : issue channel to the coprocessor
//   commit_*                   : commit channel to the coprocessor
//   result_*                   : result channel from the coprocessor
//   protocol_err_o             : sticky, mismatched result ID or timeout
//   dbg_state_o                : current FSM state
// -----------------------------------------------------------------------------
module xif_offload_ctrl
    import coproc_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH     = 4,
    parameter int unsigned X_NUM_RS       = 2,
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    // core side
    input  logic                               core_valid_i,
    output logic                               core_ready_o,
    input  logic [31:0]                        core_instr_i,
    input  logic [X_NUM_RS-1:0][XLEN-1:0]      core_rs_i,
    input  logic [X_NUM_RS-1:0]                core_rs_valid_i,
    input  logic                               core_flush_i,
    output logic                               core_illegal_o,
    output logic                               wb_valid_o,
    output logic [4:0]                         wb_rd_o,
    output logic [XLEN-1:0]                    wb_data_o,
    output logic                               wb_exc_o,
    output logic [5:0]                         wb_exccode_o,
    // issue channel
    output logic                               issue_valid_o,
    input  logic                               issue_ready_i,
    output logic [31:0]                        issue_req_instr_o,
    output logic [1:0]                         issue_req_mode_o,
    output logic [X_ID_WIDTH-1:0]              issue_req_id_o,
    output logic [X_NUM_RS-1:0][XLEN-1:0]      issue_req_rs_o,
    output logic [X_NUM_RS-1:0]                issue_req_rs_valid_o,
    input  logic                               issue_resp_accept_i,
    input  logic                               issue_resp_writeback_i,
    // commit channel
    output logic                               commit_valid_o,
    output logic [X_ID_WIDTH-1:0]              commit_id_o,
    output logic                               commit_kill_o,
    // result channel
    input  logic                               result_valid_i,
    output logic                               result_ready_o,
    input  logic [X_ID_WIDTH-1:0]              result_id_i,
    input  logic [XLEN-1:0]                    result_data_i,
    input  logic [4:0]                         result_rd_i,
    input  logic                               result_we_i,
    input  logic                               result_exc_i,
    input  logic [5:0]                         result_exccode_i,
    // status
    output logic                               protocol_err_o,
    output xif_state_e                         dbg_state_o
);

    xif_state_e              state_q;
    logic                    accept_q;
    logic                    writeback_q;
    logic                    flush_seen_q;
    logic [X_ID_WIDTH-1:0]   next_id;
    logic                    id_inc;
    logic                    id_match;
    logic                    flush_now;
    logic                    timeout;

    // The generator's value is the ID of the next instruction; it is sampled
    // at acceptance and advances on the issue handshake.
    assign id_inc = (state_q == ST_ISSUE) && issue_ready_i;

    xif_id_gen #(
        .WIDTH (X_ID_WIDTH)
    ) u_id_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (id_inc),
        .id_o   (next_id)
    );

    // Gate with rst_ni so the core sees "not ready" for the whole reset.
    assign core_ready_o     = rst_ni && (state_q == ST_IDLE);
    assign result_ready_o   = (state_q == ST_WAIT_RES);
    assign issue_req_mode_o = 2'b11;
    assign dbg_state_o      = state_q;

    // issue_req_id_o holds the in-flight ID for the whole offload.
    assign id_match = (result_id_i == issue_req_id_o);

    // A flush seen in the same cycle as the issue handshake must still kill.
    assign flush_now = flush_seen_q || core_flush_i;

`ifdef XIF_RESULT_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;

    assign timeout = (state_q == ST_WAIT_RES) &&
                     (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_WAIT_RES) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end
`else
    logic [31:0] unused_timeout_cycles;

    assign timeout               = 1'b0;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q              <= ST_IDLE;
            accept_q             <= 1'b0;
            writeback_q          <= 1'b0;
            flush_seen_q         <= 1'b0;
            core_illegal_o       <= 1'b0;
            wb_valid_o           <= 1'b0;
            wb_rd_o              <= '0;
            wb_data_o            <= '0;
            wb_exc_o             <= 1'b0;
            wb_exccode_o         <= '0;
            issue_valid_o        <= 1'b0;
            issue_req_instr_o    <= '0;
            issue_req_id_o       <= '0;
            issue_req_rs_o       <= '0;
            issue_req_rs_valid_o <= '0;
            commit_valid_o       <= 1'b0;
            commit_id_o          <= '0;
            commit_kill_o        <= 1'b0;
            protocol_err_o       <= 1'b0;
        end else begin
            // single-cycle pulses
            core_illegal_o <= 1'b0;
            wb_valid_o     <= 1'b0;
            commit_valid_o <= 1'b0;
            commit_kill_o  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (core_valid_i) begin
                        issue_valid_o        <= 1'b1;
                        issue_req_instr_o    <= core_instr_i;
                        issue_req_rs_o       <= core_rs_i;
                        issue_req_rs_valid_o <= core_rs_valid_i;
                        issue_req_id_o       <= next_id;
                        state_q              <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (core_flush_i) begin
                        flush_seen_q <= 1'b1;
                    end
                    if (issue_ready_i) begin
                        issue_valid_o  <= 1'b0;
                        accept_q       <= issue_resp_accept_i;
                        writeback_q    <= issue_resp_writeback_i;
                        commit_valid_o <= 1'b1;
                        commit_id_o    <= issue_req_id_o;
                        commit_kill_o  <= !issue_resp_accept_i || flush_now;
                        core_illegal_o <= !issue_resp_accept_i && !flush_now;
                        state_q        <= ST_COMMIT;
                    end
                end

                ST_COMMIT: begin
                    if (accept_q) begin
                        if (core_flush_i) begin
                            flush_seen_q <= 1'b1;
                        end
                        state_q <= ST_WAIT_RES;
                    end else begin
                        // rejected: no result will come back
                        flush_seen_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end

                ST_WAIT_RES: begin
                    if (result_valid_i && id_match) begin
                        // killed results are dropped unless they carry an exception
                        wb_valid_o   <= (writeback_q && result_we_i && !flush_seen_q) ||
                                        result_exc_i;
                        wb_exc_o     <= result_exc_i;
                        wb_rd_o      <= result_rd_i;
                        wb_data_o    <= result_data_i;
                        wb_exccode_o <= result_exccode_i;
                        flush_seen_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else if (timeout) begin
                        wb_valid_o     <= 1'b1;
                        wb_exc_o       <= 1'b1;
                        wb_rd_o        <= '0;
                        wb_data_o      <= '0;
                        wb_exccode_o   <= EXCCODE_TIMEOUT;
                        protocol_err_o <= 1'b1;
                        flush_seen_q   <= 1'b0;
                        state_q        <= ST_IDLE;
                    end else if (result_valid_i) begin
                        // stray beat for another ID: consume it and keep waiting
                        protocol_err_o <= 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/xif_offload_ctrl.md
# xif_offload_ctrl

Core-side initiator of the eXtension interface: takes an instruction the core's decoder cannot execute natively, offloads it to the coprocessor over the issue, commit and result channels, and returns the coprocessor's writeback (or an illegal-instruction/exception indication) to the core pipeline. One offload is in flight at a time; the core stalls on `core_ready_o` while the block is busy. Sits between decode/execute and the coprocessor, and drives the opposite end of the coprocessor's issue/commit/result ports.

## Interface
- `X_ID_WIDTH`, 4: width of the transaction ID.
- `X_NUM_RS`, 2: number of source operands forwarded.
- `XLEN`, 32: register width.
- `TIMEOUT_CYCLES`, 255: result timeout, used only with the macro.

Ports:
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `core_valid_i` in 1: an offload request is present.
- `core_ready_o` out 1: block idle; request accepted on `core_valid_i & core_ready_o`.
- `core_instr_i` in 32: the instruction word.
- `core_rs_i` in `X_NUM_RS`×`XLEN`: operand values.
- `core_rs_valid_i` in `X_NUM_RS`: operand valid flags.
- `core_flush_i` in 1: the pipeline flushed the in-flight instruction.
- `core_illegal_o` out 1: one-cycle pulse when the coprocessor rejected the instruction.
- `wb_valid_o` out 1: one-cycle writeback pulse.
- `wb_rd_o` out 5: destination register.
- `wb_data_o` out `XLEN`: writeback data.
- `wb_exc_o` out 1: the result carried an exception; qualified by `wb_valid_o`.
- `wb_exccode_o` out 6: the exception code.
- `issue_valid_o` out 1: issue channel valid.
- `issue_ready_i` in 1: issue channel ready.
- `issue_req_instr_o` out 32: issued instruction.
- `issue_req_mode_o` out 2: privilege mode, tied to 2'b11.
- `issue_req_id_o` out `X_ID_WIDTH`: issued ID.
- `issue_req_rs_o` out `X_NUM_RS`×`XLEN`: issued operands.
- `issue_req_rs_valid_o` out `X_NUM_RS`: issued operand valid flags.
- `issue_resp_accept_i` in 1: coprocessor accepts the instruction.
- `issue_resp_writeback_i` in 1: the instruction writes `rd`.
- `commit_valid_o` out 1: commit channel valid.
- `commit_id_o` out `X_ID_WIDTH`: committed ID.
- `commit_kill_o` out 1: the instruction is killed.
- `result_valid_i` in 1: result channel valid.
- `result_ready_o` out 1: result channel ready.
- `result_id_i` in `X_ID_WIDTH`: result ID.
- `result_data_i` in `XLEN`: result data.
- `result_rd_i` in 5: result destination register.
- `result_we_i` in 1: result write enable.
- `result_exc_i` in 1: result exception flag.
- `result_exccode_i` in 6: result exception code.
- `protocol_err_o` out 1: sticky flag for a result with a mismatched ID (or a timeout).

## Operation
- **FSM states:** IDLE, ISSUE, COMMIT, WAIT_RES.
- **IDLE:**
  - `core_ready_o`=1.
  - On acceptance, register the instruction, operands and the current ID, then go to ISSUE.
- **ISSUE:**
  - `issue_valid_o`=1; the request fields stay stable until `issue_ready_i`.
  - On the handshake, latch `accept` and `writeback`, then go to COMMIT.
- **COMMIT:**
  - `commit_valid_o`=1 for exactly one cycle, with `commit_id_o`=current ID.
  - `commit_kill_o = ~accept | flush_seen`.
  - If `~accept`: pulse `core_illegal_o` in this cycle (suppressed when `flush_seen`), then go to IDLE.
  - Otherwise go to WAIT_RES.
- **WAIT_RES:**
  - `result_ready_o`=1.
  - On `result_valid_i` with `result_id_i`==current ID, go to IDLE.
  - In the next cycle, pulse `wb_valid_o` if `(writeback & result_we_i & ~flush_seen) | result_exc_i`. Set `wb_exc_o` from `result_exc_i`. `wb_rd_o`/`wb_data_o`/`wb_exccode_o` are registered from the result.
  - On a mismatched ID: consume the beat, set `protocol_err_o`, and stay in WAIT_RES.
- **Kill rule:** every accepted instruction returns exactly one result, including killed ones. A killed result is consumed and discarded, except that an exception is still reported.
- **ID counter:** increments on every issue handshake and wraps modulo 2^`X_ID_WIDTH` (15→0).
- **Flush:**
  - `core_flush_i` in ISSUE or COMMIT sets `flush_seen`.
  - The issue request is never retracted once valid.
  - `flush_seen` clears on return to IDLE.
  - `core_flush_i` in IDLE has no effect.
- **Reset:**
  - Reset is asynchronous, mid-operation included.
  - Return to IDLE, clear the ID counter and `protocol_err_o`.
  - All outputs are 0 except `core_ready_o`=0 while reset is asserted and 1 in the first cycle after release. `issue_req_mode_o` stays 2'b11 (tie-off).

## Timing
- All outputs are registered, except that `core_ready_o` and `result_ready_o` decode the state register.
- Best case:
  - c0: accept.
  - c1: `issue_valid_o` high and `issue_ready_i`=1.
  - c2: `commit_valid_o`.
  - c3: `result_valid_i` (earliest; `result_ready_o` is high from c3).
  - c4: `wb_valid_o`.
- Total: 4 cycles accept→writeback; `core_ready_o` is high again in c4.
- A result arriving in the commit cycle is not accepted until WAIT_RES, one cycle later.

## Configuration
- **`XIF_RESULT_TIMEOUT_EN` defined:**
  - A counter in WAIT_RES reaching `TIMEOUT_CYCLES` forces a return to IDLE.
  - It pulses `wb_valid_o` with `wb_exc_o`=1 and `wb_exccode_o`=6'h3F, and sets `protocol_err_o`.
  - A late result for that ID arriving in IDLE is ignored; `result_ready_o` stays 0.
- **Not defined:** no counter; WAIT_RES waits indefinitely.

## Structure
- **Shared package `coproc_pkg`:**
  - The FSM state enum.
  - The coprocessor opcode enum (RMLD 7'h08, RMST 7'h09, TEST 7'h0A).
  - The timeout exception code 6'h3F.
- **Sub-module:** the wrapping ID generator, `xif_id_gen` (counter with increment enable).

## Test plan
- TEST (opcode 7'h0A, rd=5), `issue_ready_i`=1, accept=1, writeback=1, result data 32'hDEADBEEF with the matching ID → commit kill=0, `wb_valid_o` with rd=5 and data 32'hDEADBEEF, 4 cycles after acceptance.
- Opcode 7'h7F with accept=0 → `commit_kill_o`=1 in the commit cycle, `core_illegal_o` pulse, no `result_ready_o`, back to IDLE.
- `issue_ready_i` held low 3 cycles with `core_flush_i` pulsed in ISSUE → request stable throughout, `commit_kill_o`=1, result consumed, no `wb_valid_o`.
- 17 consecutive offloads → IDs 0..15 then 0; one result with the wrong ID → `protocol_err_o`=1, FSM waits for the correct ID.
- `rst_ni` asserted in WAIT_RES → all outputs 0 immediately, ID restarts at 0.
- With `XIF_RESULT_TIMEOUT_EN` defined and no result → after 255 cycles, `wb_exc_o`=1 with code 6'h3F, `protocol_err_o`=1.
